ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage and upstream of MEM. It registers the decode-to-execute bus and evaluates the one-hot ALU operation. It issues the data-SRAM request and returns a forwarding tuple to decode. It also owns HI/LO and an iterative 32-cycle divider for `div`/`divu`, stalling the pipeline while that divider runs.

## Interface
- `ID_TO_EX_WD`, 159: decode-to-execute bus width.
- `EX_TO_MEM_WD`, 76: execute-to-MEM bus width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 6 (`StallBus`): global stall vector. EX input register uses bits [2] and [3].
- `id_to_ex_bus` in 159: {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_val[63:32], rt_val[31:0]}.
- `ex_to_mem_bus` out 76: {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}, MSB first.
- `ex_to_id_bus` out 38: {rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- `ex_is_load` out 1: a load is in EX. Decode uses it for load-use stall.
- `stallreq_for_ex` out 1: divider busy.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32.

## Operation
- **Input register**
  - Reset: cleared to zero, which is a bubble.
  - stall[2]=Stop and stall[3]=NoStop: load zero (bubble).
  - stall[2]=NoStop: load `id_to_ex_bus`.
  - Otherwise: hold.
- **src1**: one-hot `sel_alu_src1`. [0] selects rs_val, [1] selects pc, [2] selects zero-extended inst[10:6].
- **src2**: one-hot `sel_alu_src2`. [0] selects rt_val, [1] selects sign-extended imm, [2] selects 32'd8, [3] selects zero-extended imm.
- **ALU ops**
  - alu_op MSB→LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub wrap modulo 2^32 with no overflow trap.
  - slt is signed and sltu unsigned; both yield 0/1.
  - Shifts shift src2 by src1[4:0].
  - lui yields {src2[15:0],16'h0}.
  - All-zero alu_op yields 0.
- **Execute decode from inst**: EX itself decodes `div`, `divu`, `mfhi`, `mflo`, `mthi`, `mtlo` from inst (opcode 0; funct 1A, 1B, 10, 12, 11, 13).
- **ex_result**: mfhi→HI, mflo→LO, otherwise the ALU result.
- **mthi/mtlo**: write rs_val into HI/LO at the clock edge ending the EX cycle.
- **Memory request**
  - `data_sram_en` = data_ram_en.
  - `data_sram_wen` = data_ram_wen & {4{data_ram_en}}.
  - `data_sram_addr` = ex_result.
  - `data_sram_wdata` = rt_val.
- **Load flags**: `ex_is_load` and outgoing `sel_rf_res` are both data_ram_en & (data_sram_wen==0).
- **Divider FSM**
  - States: IDLE, RUN, DONE.
  - IDLE→RUN when a div/divu is in EX and `div_done` is clear. Operands are latched as magnitudes (signed div only) and the counter is set to 0.
  - RUN: one restoring step per cycle. Go to DONE when counter=31, after 32 steps.
  - IDLE→DONE directly if divisor=0.
  - DONE→IDLE unconditionally. This edge writes the results: LO=quotient, HI=remainder, and sets `div_done`.
- **Signed fixup** (div only): the quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- **Divide by zero**: LO=32'hFFFF_FFFF, HI=rs_val.
- **div_done**: cleared whenever the input register loads a new instruction. This prevents a re-divide while a downstream stall holds the div in EX.
- **stallreq_for_ex** = (div or divu) in EX & ~div_done & ~(state==DONE).

## Timing
- **Reset values**: all outputs 0; HI, LO and the counter 0; state IDLE; div_done 0.
- **Reset mid-division**: the FSM aborts to IDLE and HI/LO are zeroed.
- **ALU/memory path**: the input register is the only register. Outputs are valid in the same cycle the instruction is in EX. MEM registers them on the next edge.
- **Divide latency**
  - div with nonzero divisor occupies EX for 34 cycles. Cycle 0 is IDLE/latch, cycles 1–32 are RUN, cycle 33 is DONE.
  - `stallreq_for_ex` is high in cycles 0–32 and low in cycle 33.
  - Divide by zero takes 2 cycles, with stall high in cycle 0 only.
- **HI/LO visibility**: a mfhi/mflo entering EX the cycle after DONE, or after mthi/mtlo, reads the new value. No bypass is needed.
- **Bubbles** (all-zero inst decodes as sll $0): must produce rf_we=0 and data_sram_en=0, and must never start the divider.

## Structure
- **lib/defines.vh**:
  - Add `EX_TO_MEM_WD` (76) and the divider state encodings `DIV_IDLE`/`DIV_RUN`/`DIV_DONE`.
  - Reuse `StallBus`, `Stop`, `NoStop`, `ID_TO_EX_WD`.
- **Sub-module `div_iter`**:
  - Contains the FSM, the 5-bit counter, 64-bit remainder/quotient shift register, and the sign fixup.
  - Ports: start, signed_op, a, b, busy, done, quot, rem.

## Test plan
- **addu**: rs_val=7, rt_val=0xFFFFFFFF, alu_op add, src1/src2=rs/rt, rf_we=1, waddr=3 → same cycle ex_to_id_bus={1,3,6}, data_sram_en=0.
- **lui / jal**: lui with imm 0x1234 → ex_result 0x12340000. jal at pc 0xBFC00000 → ex_result 0xBFC00008, waddr 31.
- **Signed div**: div rs=-7, rt=2 → stallreq high 33 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following mflo yields 0xFFFFFFFD.
- **Unsigned div and divide by zero**: divu 0xFFFFFFFF/16 → LO=0x0FFFFFFF, HI=0xF. div by 0 with rs=5 → stall 1 cycle, LO=0xFFFFFFFF, HI=5.
- **Downstream hold**: hold stall[3]=Stop for 5 cycles after DONE → no restart, stallreq stays low, HI/LO unchanged.
- **Reset mid-division**: assert rst low at RUN cycle 10 → all outputs and HI/LO read 0, state IDLE. The first div after release runs the full 34 cycles correctly.

Source files
------------

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pkg
// Purpose  : Bus widths, stall encodings, ID->EX bus layout and divider states
// Revision : 1.0
// ============================================================================
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Bit positions inside the one-hot alu_op field
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
    } id_to_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : 32-step restoring divider with sign fixup and divide-by-zero path
// Revision : 1.0
// ============================================================================
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;   // {remainder, quotient}
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;

    logic [32:0] cand;
    logic        ge;
    logic [31:0] sub;

    always_comb begin
        cand    = acc_q[63:31];
        ge      = (cand >= {1'b0, dvs_q});
        sub     = cand[31:0] - dvs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    q_neg_d = signed_op & (a[31] ^ b[31]);
                    r_neg_d = signed_op & a[31];
                    cnt_d   = 5'd0;
                    if (b == 32'd0) begin
                        // Quotient all-ones and the raw dividend as remainder
                        dz_d    = 1'b1;
                        acc_d   = {a, 32'hFFFF_FFFF};
                        state_d = DIV_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {32'd0, (signed_op && a[31]) ? -a : a};
                        dvs_d   = (signed_op && b[31]) ? -b : b;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                acc_d = {(ge ? sub : cand[31:0]), acc_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != DIV_IDLE);
    assign done = (state_q == DIV_DONE);
    assign quot = (!dz_q && q_neg_q) ? -acc_q[31:0]  : acc_q[31:0];
    assign rem  = (!dz_q && r_neg_q) ? -acc_q[63:32] : acc_q[63:32];

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage: ALU, data-SRAM request, HI/LO and divider
// Revision : 1.0
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t   ex_q, ex_d;
    logic        load_new;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        div_done_q, div_done_d;

    logic [5:0]  funct;
    logic        op_special, is_div, is_divs, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic [31:0] src1, src2, imm_s, imm_z, alu_res, ex_result;
    logic        div_busy, div_fin;
    logic [31:0] div_quot, div_rem;
    logic        unused_bits;

    always_comb begin
        ex_d     = ex_q;
        load_new = 1'b0;
        if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_d     = '0;
            load_new = 1'b1;
        end else if (stall[2] == NO_STOP) begin
            ex_d     = id_to_ex_bus;
            load_new = 1'b1;
        end
    end

    assign op_special = (ex_q.inst[31:26] == 6'd0);
    assign funct      = ex_q.inst[5:0];
    assign is_divs    = op_special && (funct == FUNCT_DIV);
    assign is_div     = is_divs || (op_special && (funct == FUNCT_DIVU));
    assign is_mfhi    = op_special && (funct == FUNCT_MFHI);
    assign is_mflo    = op_special && (funct == FUNCT_MFLO);
    assign is_mthi    = op_special && (funct == FUNCT_MTHI);
    assign is_mtlo    = op_special && (funct == FUNCT_MTLO);

    assign imm_s = sext16(ex_q.inst[15:0]);
    assign imm_z = {16'd0, ex_q.inst[15:0]};

    always_comb begin
        src1 = 32'd0;
        src2 = 32'd0;
        if (ex_q.sel_alu_src1[0]) src1 |= ex_q.rs_val;
        if (ex_q.sel_alu_src1[1]) src1 |= ex_q.pc;
        if (ex_q.sel_alu_src1[2]) src1 |= {27'd0, ex_q.inst[10:6]};
        if (ex_q.sel_alu_src2[0]) src2 |= ex_q.rt_val;
        if (ex_q.sel_alu_src2[1]) src2 |= imm_s;
        if (ex_q.sel_alu_src2[2]) src2 |= 32'd8;
        if (ex_q.sel_alu_src2[3]) src2 |= imm_z;
    end

    // Each one-hot op contributes its result; an empty alu_op yields zero
    always_comb begin
        alu_res = 32'd0;
        if (ex_q.alu_op[OP_ADD])  alu_res |= src1 + src2;
        if (ex_q.alu_op[OP_SUB])  alu_res |= src1 - src2;
        if (ex_q.alu_op[OP_SLT])  alu_res |= {31'd0, $signed(src1) < $signed(src2)};
        if (ex_q.alu_op[OP_SLTU]) alu_res |= {31'd0, src1 < src2};
        if (ex_q.alu_op[OP_AND])  alu_res |= src1 & src2;
        if (ex_q.alu_op[OP_NOR])  alu_res |= ~(src1 | src2);
        if (ex_q.alu_op[OP_OR])   alu_res |= src1 | src2;
        if (ex_q.alu_op[OP_XOR])  alu_res |= src1 ^ src2;
        if (ex_q.alu_op[OP_SLL])  alu_res |= src2 << src1[4:0];
        if (ex_q.alu_op[OP_SRL])  alu_res |= src2 >> src1[4:0];
        if (ex_q.alu_op[OP_SRA])  alu_res |= $unsigned($signed(src2) >>> src1[4:0]);
        if (ex_q.alu_op[OP_LUI])  alu_res |= {src2[15:0], 16'h0000};
    end

    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div && !div_done_q),
        .signed_op (is_divs),
        .a         (ex_q.rs_val),
        .b         (ex_q.rt_val),
        .busy      (div_busy),
        .done      (div_fin),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_done_d = div_done_q;
        if (div_fin) begin
            lo_d       = div_quot;
            hi_d       = div_rem;
            div_done_d = 1'b1;
        end else begin
            if (is_mthi) hi_d = ex_q.rs_val;
            if (is_mtlo) lo_d = ex_q.rs_val;
        end
        // A newly loaded instruction must be free to start its own divide
        if (load_new) div_done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q       <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            div_done_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_done_q <= div_done_d;
        end
    end

    assign stallreq_for_ex = is_div && !div_done_q && !div_fin;

    assign data_sram_en    = ex_q.data_ram_en;
    assign data_sram_wen   = ex_q.data_ram_wen & {4{ex_q.data_ram_en}};
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = ex_q.rt_val;
    assign ex_is_load      = ex_q.data_ram_en && (data_sram_wen == 4'd0);

    assign ex_to_mem_bus = {ex_q.pc, ex_q.data_ram_en, ex_q.data_ram_wen, ex_is_load,
                            ex_q.rf_we, ex_q.rf_waddr, ex_result};
    assign ex_to_id_bus  = {ex_q.rf_we, ex_q.rf_waddr, ex_result};

    assign unused_bits = ^{ex_q.inst[25:16], ex_q.sel_rf_res, stall[5:4], stall[1:0], div_busy};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Randomized and directed self-checking bench for ex_stage
// Revision : 1.0
// ============================================================================
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_WD-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    ex_is_load, stallreq_for_ex, data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr, data_sram_wdata;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference HI/LO and the fields of the instruction currently in EX
    logic [31:0] m_hi, m_lo;
    logic [31:0] c_pc, c_rt;
    logic        c_en, c_we;
    logic [3:0]  c_wen;
    logic [4:0]  c_wa;

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
                       input logic [2:0] s1, input logic [3:0] s2, input logic en,
                       input logic [3:0] wen, input logic we, input logic [4:0] wa,
                       input logic [31:0] rs, input logic [31:0] rt);
        c_pc = pc; c_rt = rt; c_en = en; c_wen = wen; c_we = we; c_wa = wa;
        id_to_ex_bus = {pc, inst, op, s1, s2, en, wen, we, wa, 1'($urandom), rs, rt};
    endtask

    task automatic issue();
        stall = 6'b000000;
        step();
    endtask

    task automatic check_ex(input string tag, input logic [31:0] res);
        logic ld;
        ld = c_en && (c_wen == 4'd0);
        chk({tag, "_mem"}, ex_to_mem_bus, {c_pc, c_en, c_wen, ld, c_we, c_wa, res});
        chk({tag, "_id"}, 76'(ex_to_id_bus), 76'({c_we, c_wa, res}));
        chk({tag, "_sram"}, 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load}),
            76'({c_en, (c_en ? c_wen : 4'd0), res, c_rt, ld}));
        chk({tag, "_stallreq"}, 76'(stallreq_for_ex), 76'(1'b0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // op index 0..11 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui; 12 = none
    function automatic logic [31:0] ref_alu(input int op, input int s1, input int s2,
                                            input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] x, y;
        logic [4:0]  sh;
        case (s1)
            0:       x = rs;
            1:       x = pc;
            2:       x = {27'd0, inst[10:6]};
            default: x = 32'd0;
        endcase
        case (s2)
            0:       y = rt;
            1:       y = {{16{inst[15]}}, inst[15:0]};
            2:       y = 32'd8;
            3:       y = {16'd0, inst[15:0]};
            default: y = 32'd0;
        endcase
        sh = x[4:0];
        case (op)
            0:       return x + y;
            1:       return x - y;
            2:       return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3:       return (x < y) ? 32'd1 : 32'd0;
            4:       return x & y;
            5:       return ~(x | y);
            6:       return x | y;
            7:       return x ^ y;
            8:       return y << sh;
            9:       return y >> sh;
            10:      return $unsigned($signed(y) >>> sh);
            11:      return {y[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    task automatic mf(input string tag, input bit hi);
        put(32'h0040_0100, {6'd0, 10'd0, 5'd9, 5'd0, (hi ? FUNCT_MFHI : FUNCT_MFLO)}, 12'd0,
            3'b000, 4'b0000, 1'b0, 4'd0, 1'b1, 5'd9, pick(), pick());
        issue();
        check_ex(tag, hi ? m_hi : m_lo);
    endtask

    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b);
        int cnt;
        logic [31:0] q, r;
        put(32'h0040_0200, {6'd0, 5'd1, 5'd2, 10'd0, (sgn ? FUNCT_DIV : FUNCT_DIVU)}, 12'd0,
            3'b001, 4'b0001, 1'b0, 4'd0, 1'b0, 5'd0, a, b);
        issue();
        cnt = 0;
        while (stallreq_for_ex && cnt < 100) begin
            cnt++;
            stall = 6'b001111;
            step();
        end
        chk({tag, "_stall_cycles"}, 76'(cnt), 76'((b == 32'd0) ? 1 : 33));
        check_ex({tag, "_done"}, 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        m_lo = q;
        m_hi = r;
    endtask

    initial begin
        int          op, s1, s2;
        logic [31:0] inst, rs, rt, pc, a, b;
        logic [3:0]  wen;
        logic        en, we, sgn;
        logic [4:0]  wa;

        rst = 1'b0;
        stall = 6'b000000;
        m_hi = 32'd0;
        m_lo = 32'd0;
        put(32'd0, 32'd0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_ex("reset", 32'd0);
        rst = 1'b1;
        step();
        check_ex("bubble", 32'd0);

        put(32'h0040_0000, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 12'h800, 3'b001, 4'b0001,
            1'b0, 4'd0, 1'b1, 5'd3, 32'd7, 32'hFFFF_FFFF);
        issue();
        check_ex("addu", 32'd6);

        put(32'h0040_0004, {6'h0F, 5'd0, 5'd4, 16'h1234}, 12'h001, 3'b000, 4'b1000,
            1'b0, 4'd0, 1'b1, 5'd4, pick(), pick());
        issue();
        check_ex("lui", 32'h1234_0000);

        put(32'hBFC0_0000, {6'h03, 26'h0}, 12'h800, 3'b010, 4'b0100,
            1'b0, 4'd0, 1'b1, 5'd31, pick(), pick());
        issue();
        check_ex("jal", 32'hBFC0_0008);

        for (int i = 0; i < 60; i++) begin
            op   = $urandom_range(0, 12);
            s1   = $urandom_range(0, 3);
            s2   = $urandom_range(0, 4);
            inst = $urandom;
            inst[31:26] = 6'($urandom_range(1, 63));
            pc   = $urandom;
            rs   = pick();
            rt   = pick();
            en   = 1'($urandom);
            wen  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            we   = 1'($urandom);
            wa   = 5'($urandom);
            put(pc, inst, (op < 12) ? 12'(1 << (11 - op)) : 12'd0,
                (s1 < 3) ? 3'(1 << s1) : 3'd0, (s2 < 4) ? 4'(1 << s2) : 4'd0,
                en, wen, we, wa, rs, rt);
            issue();
            check_ex("alu_rand", ref_alu(op, s1, s2, pc, inst, rs, rt));
        end

        a = $urandom;
        b = $urandom;
        put(32'h0040_0010, {6'd0, 5'd4, 15'd0, FUNCT_MTHI}, 12'd0, 3'b000, 4'b0000,
            1'b0, 4'd0, 1'b0, 5'd0, a, pick());
        issue();
        check_ex("mthi", 32'd0);
        m_hi = a;
        put(32'h0040_0014, {6'd0, 5'd5, 15'd0, FUNCT_MTLO}, 12'd0, 3'b000, 4'b0000,
            1'b0, 4'd0, 1'b0, 5'd0, b, pick());
        issue();
        check_ex("mtlo", 32'd0);
        m_lo = b;
        mf("mfhi_after_mthi", 1'b1);
        mf("mflo_after_mtlo", 1'b0);

        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        mf("div_m7_2_lo", 1'b0);
        mf("div_m7_2_hi", 1'b1);

        do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16);
        mf("divu_big_lo", 1'b0);
        mf("divu_big_hi", 1'b1);

        do_div("div_by0", 1'b1, 32'd5, 32'd0);
        mf("div_by0_lo", 1'b0);
        mf("div_by0_hi", 1'b1);

        do_div("div_hold", 1'b1, 32'd1000, 32'hFFFF_FFFD);
        for (int k = 0; k < 5; k++) begin
            stall = 6'b001111;
            step();
            chk("hold_stallreq", 76'(stallreq_for_ex), 76'(1'b0));
        end
        mf("hold_hi", 1'b1);
        mf("hold_lo", 1'b0);

        for (int i = 0; i < 6; i++) begin
            sgn = 1'($urandom);
            a   = pick();
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : pick();
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div("div_rand", sgn, a, b);
            mf("div_rand_lo", 1'b0);
            mf("div_rand_hi", 1'b1);
        end

        put(32'h0040_0300, {6'd0, 5'd1, 5'd2, 10'd0, FUNCT_DIV}, 12'd0, 3'b001, 4'b0001,
            1'b0, 4'd0, 1'b0, 5'd0, 32'hFFFF_FF9C, 32'd7);
        issue();
        for (int k = 0; k < 10; k++) begin
            stall = 6'b001111;
            step();
        end
        chk("mid_busy", 76'(stallreq_for_ex), 76'(1'b1));
        rst = 1'b0;
        #1;
        chk("rst_mem", ex_to_mem_bus, 76'd0);
        chk("rst_id", 76'(ex_to_id_bus), 76'd0);
        chk("rst_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load}), 76'd0);
        chk("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        #2;
        rst = 1'b1;
        put(32'd0, 32'd0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        issue();
        check_ex("post_rst_bubble", 32'd0);
        mf("post_rst_hi", 1'b1);
        mf("post_rst_lo", 1'b0);
        do_div("post_rst_div", 1'b1, 32'hFFFF_FF9C, 32'd7);
        mf("post_rst_div_lo", 1'b0);
        mf("post_rst_div_hi", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
